ps2_host_tx: RTL

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard. It performs the request-to-send sequence, shifts 8 data bits LSB first, then odd parity and stop, and checks the device acknowledge. It drives the shared kbd_clk/kbd_data lines through open-drain enables and sits beside the keyboard scan receiver. tx_busy gates that receiver while a command is in flight.

---
 rtl/ps2_host_tx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, then device ACK check, driving both lines through open-drain enables.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned RTS_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_kbd_clk,
    input  logic       i_kbd_data,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_kbd_clk_oe,
    output logic       o_kbd_data_oe,
    output logic       o_tx_done,
    output logic       o_tx_err
);

    localparam int unsigned MAX_A      = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_A > RTS_CYCLES) ? MAX_A : RTS_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned FRAME_W    = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_fall_cnt;
    logic [FRAME_W-1:0]   r_shreg;
    logic                 r_clk_r0, r_clk_r1, r_clk_r2;
    logic                 r_data_r0, r_data_r1;
    logic                 r_tx_ready, r_tx_busy, r_clk_oe, r_data_oe, r_tx_done, r_tx_err;
    logic                 w_fall;
    logic                 w_timeout;

    // Pin synchronizers, idle bus level at reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_r0  <= 1'b1;
            r_clk_r1  <= 1'b1;
            r_clk_r2  <= 1'b1;
            r_data_r0 <= 1'b1;
            r_data_r1 <= 1'b1;
        end else begin
            r_clk_r0  <= i_kbd_clk;
            r_clk_r1  <= r_clk_r0;
            r_clk_r2  <= r_clk_r1;
            r_data_r0 <= i_kbd_data;
            r_data_r1 <= r_data_r0;
        end
    end

    assign w_fall    = ~r_clk_r1 & r_clk_r2;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The cycle counter keeps running from SEND into WAIT_IDLE so the timeout spans release to completion
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_fall_cnt <= '0;
            r_shreg    <= '0;
            r_tx_ready <= 1'b1;
            r_tx_busy  <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tx_valid) begin
                        r_shreg    <= {1'b1, ~^i_tx_data, i_tx_data};
                        r_cnt      <= '0;
                        r_clk_oe   <= 1'b1;
                        r_data_oe  <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        r_cnt     <= '0;
                        r_data_oe <= 1'b1;
                        r_state   <= S_RTS;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RTS: begin
                    if (r_cnt == CNT_W'(RTS_CYCLES - 1)) begin
                        r_cnt      <= '0;
                        r_fall_cnt <= '0;
                        r_clk_oe   <= 1'b0;
                        r_state    <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SEND: begin
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_tx_err  <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_fall) begin
                            if (r_fall_cnt == 4'd10) begin
                                if (r_data_r1) begin
                                    r_data_oe <= 1'b0;
                                    r_tx_err  <= 1'b1;
                                    r_state   <= S_ERR;
                                end else begin
                                    r_state <= S_WAIT_IDLE;
                                end
                            end else begin
                                r_data_oe  <= ~r_shreg[0];
                                r_shreg    <= {1'b0, r_shreg[FRAME_W-1:1]};
                                r_fall_cnt <= r_fall_cnt + 4'd1;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_tx_err  <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_clk_r1 && r_data_r1) begin
                            r_tx_done <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                    r_tx_ready <= 1'b1;
                    r_tx_busy  <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready    = r_tx_ready;
    assign o_tx_busy     = r_tx_busy;
    assign o_kbd_clk_oe  = r_clk_oe;
    assign o_kbd_data_oe = r_data_oe;
    assign o_tx_done     = r_tx_done;
    assign o_tx_err      = r_tx_err;

endmodule
